// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex 8N1-style UART with independent receiver and
// transmitter sharing one clock and reset. Bit timing comes from CLK_HZ / BIT_RATE.
// The receiver samples each bit at its centre, measured from the synchronized
// start edge. The transmitter drives registered outputs only.
`timescale 1ns / 1ps

module uart_transceiver #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 12_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_break,
    output logic                    uart_txd,
    input  logic                    uart_tx_en,
    output logic                    uart_tx_busy,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

    // Bit timing. The half-bit offset is clamped to one cycle so that very fast
    // bit rates still produce a valid start-bit check point.
    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int HALF_BIT       = (CYCLES_PER_BIT / 2 < 1) ? 1 : CYCLES_PER_BIT / 2;
    localparam int STOP_CYCLES    = STOP_BITS * CYCLES_PER_BIT;
    localparam int CNT_W          = $clog2(STOP_CYCLES + 1);
    localparam int IDX_W          = $clog2(PAYLOAD_BITS + 1);

    localparam logic [CNT_W-1:0] TX_BIT_END  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] TX_STOP_END = CNT_W'(STOP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RX_HALF     = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] RX_FULL     = CNT_W'(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO    = '0;
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PAYLOAD_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_t             tx_state;
    logic [CNT_W-1:0]        tx_cnt;
    logic [IDX_W-1:0]        tx_idx;
    logic [PAYLOAD_BITS-1:0] tx_shift;

    // TX frame sequencer; uart_txd and uart_tx_busy are registered so the line never glitches
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state     <= ST_IDLE;
            tx_cnt       <= CNT_ZERO;
            tx_idx       <= IDX_ZERO;
            tx_shift     <= '0;
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    uart_txd     <= 1'b1;
                    uart_tx_busy <= 1'b0;
                    tx_cnt       <= CNT_ZERO;
                    tx_idx       <= IDX_ZERO;
                    if (uart_tx_en) begin
                        tx_shift     <= uart_tx_data;
                        tx_state     <= ST_START;
                        uart_txd     <= 1'b0;
                        uart_tx_busy <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tx_cnt == TX_BIT_END) begin
                        tx_cnt   <= CNT_ZERO;
                        tx_state <= ST_DATA;
                        uart_txd <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == TX_BIT_END) begin
                        tx_cnt <= CNT_ZERO;
                        if (tx_idx == LAST_IDX) begin
                            tx_state <= ST_STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            tx_idx   <= tx_idx + IDX_ONE;
                            tx_shift <= {1'b0, tx_shift[PAYLOAD_BITS-1:1]};
                            uart_txd <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == TX_STOP_END) begin
                        tx_cnt       <= CNT_ZERO;
                        tx_state     <= ST_IDLE;
                        uart_tx_busy <= 1'b0;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                default: begin
                    tx_state     <= ST_IDLE;
                    uart_txd     <= 1'b1;
                    uart_tx_busy <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rx_sync1;
    logic rx_sync2;
    logic rx_prev;
    logic rx_fall;

    // Two-flop synchronizer plus one delay stage for falling-edge detection; resets to idle-high
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            rx_sync1 <= uart_rxd;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync2;

    uart_state_t             rx_state;
    logic [CNT_W-1:0]        rx_cnt;
    logic [IDX_W-1:0]        rx_idx;
    logic [PAYLOAD_BITS-1:0] rx_shift;

    // RX frame sequencer; rx_cnt counts cycles since the last sample point (since the edge in START)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state      <= ST_IDLE;
            rx_cnt        <= CNT_ZERO;
            rx_idx        <= IDX_ZERO;
            rx_shift      <= '0;
            uart_rx_data  <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
        end else begin
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            case (rx_state)
                ST_IDLE: begin
                    rx_cnt <= CNT_ONE;
                    rx_idx <= IDX_ZERO;
                    if (uart_rx_en && rx_fall) begin
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt == RX_HALF) begin
                        rx_cnt <= CNT_ONE;
                        rx_idx <= IDX_ZERO;
                        if (rx_sync2) begin
                            rx_state <= ST_IDLE;
                        end else begin
                            rx_state <= ST_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == RX_FULL) begin
                        rx_cnt   <= CNT_ONE;
                        rx_shift <= {rx_sync2, rx_shift[PAYLOAD_BITS-1:1]};
                        if (rx_idx == LAST_IDX) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_idx <= rx_idx + IDX_ONE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt == RX_FULL) begin
                        rx_cnt   <= CNT_ONE;
                        rx_state <= ST_IDLE;
                        if (rx_sync2) begin
                            uart_rx_data  <= rx_shift;
                            uart_rx_valid <= 1'b1;
                        end else if (rx_shift == '0) begin
                            uart_rx_break <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                default: begin
                    rx_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: directed self-checking bench for uart_transceiver.
// Runs the core at 16 clocks per bit (1.6 MHz / 100 kbit/s) to keep frames short.
`timescale 1ns / 1ps

module tb_uart_transceiver;

    localparam int CLK_HZ       = 1_600_000;
    localparam int BIT_RATE     = 100_000;
    localparam int PAYLOAD_BITS = 8;
    localparam int STOP_BITS    = 1;
    localparam int BIT_NS       = 160;

    logic       clk = 1'b0;
    logic       resetn;
    logic       uart_rxd;
    logic       uart_rx_en;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_rx_break;
    logic       uart_txd;
    logic       uart_tx_en;
    logic       uart_tx_busy;
    logic [7:0] uart_tx_data;

    logic loop_mode;
    logic rxd_drive;

    int compared    = 0;
    int mismatched  = 0;
    int valid_count = 0;
    int break_count = 0;
    logic [7:0] rx_log[$];

    int base_v;
    int base_b;
    int base_idx;
    logic [9:0] tx_frame;
    logic [31:0] got;
    logic [7:0] lb_expect[3];

    always #5 clk = ~clk;

    assign uart_rxd = loop_mode ? uart_txd : rxd_drive;

    uart_transceiver #(
        .BIT_RATE    (BIT_RATE),
        .CLK_HZ      (CLK_HZ),
        .PAYLOAD_BITS(PAYLOAD_BITS),
        .STOP_BITS   (STOP_BITS)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .uart_rxd     (uart_rxd),
        .uart_rx_en   (uart_rx_en),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_data (uart_rx_data),
        .uart_rx_break(uart_rx_break),
        .uart_txd     (uart_txd),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_busy (uart_tx_busy),
        .uart_tx_data (uart_tx_data)
    );

    // Strobe monitor on the falling edge; a strobe longer than one cycle is counted more than once
    always @(negedge clk) begin
        if (uart_rx_valid) begin
            valid_count <= valid_count + 1;
            rx_log.push_back(uart_rx_data);
        end
        if (uart_rx_break) begin
            break_count <= break_count + 1;
        end
    end

    // Watchdog so a stuck run still terminates
    initial begin
        #200_000;
        $display("[TB] FAIL watchdog: time limit expired before the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one serial frame onto the RX pin with the given bit period in ns
    task automatic apply_stimulus(input logic [7:0] payload, input logic stop_level,
                                  input int bit_ns);
        rxd_drive = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rxd_drive = payload[i];
            #(bit_ns);
        end
        rxd_drive = stop_level;
        #(bit_ns);
        rxd_drive = 1'b1;
    endtask

    // Bounded wait for uart_tx_busy to reach a level, sampled on falling edges
    task automatic wait_busy(input logic level, input int limit, input string tag);
        int n;
        n = 0;
        while (uart_tx_busy !== level && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 32'(uart_tx_busy), 32'(level));
    endtask

    initial begin
        resetn       = 1'b0;
        rxd_drive    = 1'b1;
        loop_mode    = 1'b0;
        uart_rx_en   = 1'b1;
        uart_tx_en   = 1'b0;
        uart_tx_data = 8'h00;
        lb_expect[0] = 8'h00;
        lb_expect[1] = 8'hFF;
        lb_expect[2] = 8'h3C;

        // Reset values
        repeat (4) @(negedge clk);
        check_output("reset_txd", 32'(uart_txd), 32'h1);
        check_output("reset_busy", 32'(uart_tx_busy), 32'h0);
        check_output("reset_rx_valid", 32'(uart_rx_valid), 32'h0);
        check_output("reset_rx_break", 32'(uart_rx_break), 32'h0);
        check_output("reset_rx_data", 32'(uart_rx_data), 32'h0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // TX 0x55: start 0, data 1,0,1,0,1,0,1,0 (LSB first), stop 1
        tx_frame     = {1'b1, 8'h55, 1'b0};
        uart_tx_data = 8'h55;
        uart_tx_en   = 1'b1;
        @(posedge clk);
        #1;
        uart_tx_en   = 1'b0;
        uart_tx_data = 8'hFF;
        check_output("tx_latency_busy", 32'(uart_tx_busy), 32'h1);
        check_output("tx_latency_start", 32'(uart_txd), 32'h0);
        for (int k = 0; k < 10; k++) begin
            repeat (8) @(negedge clk);
            check_output($sformatf("tx55_bit%0d", k), 32'(uart_txd), 32'(tx_frame[k]));
            if (k == 4) begin
                uart_tx_en = 1'b1;
                @(negedge clk);
                uart_tx_en = 1'b0;
                repeat (7) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
        end
        check_output("tx_busy_last_stop_cycle", 32'(uart_tx_busy), 32'h1);
        @(negedge clk);
        check_output("tx_busy_fall", 32'(uart_tx_busy), 32'h0);
        check_output("tx_idle_line", 32'(uart_txd), 32'h1);
        repeat (20) @(negedge clk);
        check_output("tx_en_ignored_while_busy", 32'(uart_tx_busy), 32'h0);

        // RX 0xA3 at nominal rate, then held through 10 idle bit times
        base_v = valid_count;
        base_b = break_count;
        apply_stimulus(8'hA3, 1'b1, BIT_NS);
        repeat (5) @(negedge clk);
        check_output("rxA3_valid_count", 32'(valid_count - base_v), 32'h1);
        check_output("rxA3_break_count", 32'(break_count - base_b), 32'h0);
        check_output("rxA3_data", 32'(uart_rx_data), 32'hA3);
        #(10 * BIT_NS);
        check_output("rxA3_data_held", 32'(uart_rx_data), 32'hA3);
        check_output("rxA3_no_extra_valid", 32'(valid_count - base_v), 32'h1);

        // Baud tolerance: +1.9% and -1.9% bit periods
        apply_stimulus(8'h5A, 1'b1, 163);
        #(BIT_NS);
        check_output("rx_slow_data", 32'(uart_rx_data), 32'h5A);
        apply_stimulus(8'hC3, 1'b1, 157);
        #(BIT_NS);
        check_output("rx_fast_data", 32'(uart_rx_data), 32'hC3);
        check_output("rx_tol_valid_count", 32'(valid_count - base_v), 32'h3);

        // Glitch shorter than half a bit
        base_v = valid_count;
        base_b = break_count;
        rxd_drive = 1'b0;
        #50;
        rxd_drive = 1'b1;
        #(2 * BIT_NS);
        check_output("glitch_no_valid", 32'(valid_count - base_v), 32'h0);
        check_output("glitch_no_break", 32'(break_count - base_b), 32'h0);

        // Receiver disabled: full 0x41 frame ignored
        uart_rx_en = 1'b0;
        apply_stimulus(8'h41, 1'b1, BIT_NS);
        #(BIT_NS);
        uart_rx_en = 1'b1;
        check_output("rx_disabled_no_valid", 32'(valid_count - base_v), 32'h0);
        check_output("rx_disabled_data_kept", 32'(uart_rx_data), 32'hC3);

        // Framing error: nonzero payload with a low stop bit
        apply_stimulus(8'h41, 1'b0, BIT_NS);
        #(2 * BIT_NS);
        check_output("framing_no_valid", 32'(valid_count - base_v), 32'h0);
        check_output("framing_no_break", 32'(break_count - base_b), 32'h0);
        check_output("framing_data_kept", 32'(uart_rx_data), 32'hC3);

        // Break: line held low for 12 bit times
        rxd_drive = 1'b0;
        #(12 * BIT_NS);
        rxd_drive = 1'b1;
        #(2 * BIT_NS);
        check_output("break_once", 32'(break_count - base_b), 32'h1);
        check_output("break_no_valid", 32'(valid_count - base_v), 32'h0);
        check_output("break_data_kept", 32'(uart_rx_data), 32'hC3);

        // Loopback with 0x00, 0xFF, 0x3C back-to-back
        loop_mode = 1'b1;
        @(negedge clk);
        base_v   = valid_count;
        base_idx = rx_log.size();
        uart_tx_data = 8'h00;
        uart_tx_en   = 1'b1;
        wait_busy(1'b1, 5, "lb_frame0_start");
        uart_tx_data = 8'hFF;
        wait_busy(1'b0, 200, "lb_frame0_end");
        check_output("lb_gap0_txd_idle", 32'(uart_txd), 32'h1);
        @(negedge clk);
        check_output("lb_gap0_busy", 32'(uart_tx_busy), 32'h1);
        check_output("lb_gap0_start", 32'(uart_txd), 32'h0);
        uart_tx_data = 8'h3C;
        wait_busy(1'b0, 200, "lb_frame1_end");
        @(negedge clk);
        check_output("lb_gap1_busy", 32'(uart_tx_busy), 32'h1);
        check_output("lb_gap1_start", 32'(uart_txd), 32'h0);
        uart_tx_en = 1'b0;
        wait_busy(1'b0, 200, "lb_frame2_end");
        repeat (20) @(negedge clk);
        check_output("lb_valid_count", 32'(valid_count - base_v), 32'h3);
        for (int i = 0; i < 3; i++) begin
            got = (rx_log.size() > base_idx + i) ? 32'(rx_log[base_idx + i]) : 32'hDEAD;
            check_output($sformatf("lb_byte%0d", i), got, 32'(lb_expect[i]));
        end
        check_output("lb_tx_stays_idle", 32'(uart_tx_busy), 32'h0);

        // Reset mid-frame on both halves
        loop_mode = 1'b0;
        base_v = valid_count;
        base_b = break_count;
        uart_tx_data = 8'hA5;
        uart_tx_en   = 1'b1;
        @(posedge clk);
        #1;
        uart_tx_en = 1'b0;
        fork
            apply_stimulus(8'h96, 1'b1, BIT_NS);
            begin
                repeat (70) @(negedge clk);
                resetn = 1'b0;
                #1;
                check_output("midrst_txd_immediate", 32'(uart_txd), 32'h1);
                check_output("midrst_busy_immediate", 32'(uart_tx_busy), 32'h0);
                check_output("midrst_rx_data_cleared", 32'(uart_rx_data), 32'h0);
            end
        join
        repeat (3) @(negedge clk);
        check_output("midrst_no_valid", 32'(valid_count - base_v), 32'h0);
        check_output("midrst_no_break", 32'(break_count - base_b), 32'h0);
        resetn = 1'b1;
        loop_mode = 1'b1;
        repeat (3) @(negedge clk);
        uart_tx_data = 8'h81;
        uart_tx_en   = 1'b1;
        wait_busy(1'b1, 5, "post_rst_tx_start");
        uart_tx_en = 1'b0;
        wait_busy(1'b0, 200, "post_rst_tx_end");
        repeat (20) @(negedge clk);
        check_output("post_rst_valid", 32'(valid_count - base_v), 32'h1);
        check_output("post_rst_data", 32'(uart_rx_data), 32'h81);
        check_output("post_rst_no_break", 32'(break_count - base_b), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
